// File: rtl/lstm_pkg.sv
// Shared constants, FSM encoding and saturation helper for the LSTM gate sequencer.
package lstm_pkg;

  localparam int FP8_W  = 8;
  localparam int FSD8_W = 8;
  localparam int FP16_W = 16;

  localparam logic [1:0] GATE_F = 2'd0;
  localparam logic [1:0] GATE_I = 2'd1;
  localparam logic [1:0] GATE_G = 2'd2;
  localparam logic [1:0] GATE_O = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_BIAS,
    S_OUT,
    S_FIN
  } state_t;

  // Clamp a signed sum to the 16-bit pre-activation range.
  function automatic logic [FP16_W-1:0] sat16(input logic signed [31:0] v);
    if (v > 32'sd32767) return 16'h7FFF;
    else if (v < -32'sd32768) return 16'h8000;
    else return v[15:0];
  endfunction

endpackage

// File: rtl/lstm_operand_pipe.sv
// Aligns issued activations with the 1-cycle weight read, feeds the MAC and
// accumulates its registered result two cycles after issue.
module lstm_operand_pipe
  import lstm_pkg::*;
#(
  parameter int ACC_W = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    issue,
  input  logic                    acc_clr,
  input  logic [FP8_W-1:0]        act_in,
  input  logic [FSD8_W-1:0]       wmem_data,
  input  logic [FP16_W-1:0]       mac_psum,
  output logic [FSD8_W-1:0]       mac_weight,
  output logic [FP8_W-1:0]        mac_act,
  output logic signed [ACC_W-1:0] acc
);

  logic [FP8_W-1:0] act_d;
  logic             v1;
  logic             v2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_d <= '0;
      v1    <= 1'b0;
      v2    <= 1'b0;
      acc   <= '0;
    end else if (flush) begin
      act_d <= '0;
      v1    <= 1'b0;
      v2    <= 1'b0;
      acc   <= '0;
    end else begin
      act_d <= issue ? act_in : '0;
      v1    <= issue;
      v2    <= v1;
      if (acc_clr) acc <= '0;
      else if (v2) acc <= acc + ACC_W'($signed(mac_psum));
    end
  end

  // Operands are forced to zero outside the operand stage.
  assign mac_weight = v1 ? wmem_data : '0;
  assign mac_act    = v1 ? act_d : '0;

endmodule

// File: rtl/lstm_gate_sequencer.sv
// Sequences one shared MAC over the F/I/G/O gate rows of one LSTM timestep and
// hands each biased, saturated pre-activation out over valid/ready.
module lstm_gate_sequencer
  import lstm_pkg::*;
#(
  parameter int N_X    = 4,
  parameter int N_H    = 4,
  parameter int ADDR_W = 6,
  parameter int ACC_W  = 24,
  localparam int IDX_W = ($clog2((N_X > N_H) ? N_X : N_H) < 1) ? 1 :
                          $clog2((N_X > N_H) ? N_X : N_H)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              wmem_rd_en,
  output logic [ADDR_W-1:0] wmem_addr,
  input  logic [FSD8_W-1:0] wmem_data,
  output logic              act_sel,
  output logic [IDX_W-1:0]  act_idx,
  input  logic [FP8_W-1:0]  act_data,
  output logic [1:0]        bias_idx,
  input  logic [FP16_W-1:0] bias_data,
  output logic [FSD8_W-1:0] mac_weight,
  output logic [FP8_W-1:0]  mac_act,
  input  logic [FP16_W-1:0] mac_psum,
  output logic              gate_valid,
  input  logic              gate_ready,
  output logic [1:0]        gate_id,
  output logic [FP16_W-1:0] gate_preact
);

  localparam int ROW = N_X + N_H;
  localparam int K_W = ($clog2(ROW) < 1) ? 1 : $clog2(ROW);

  state_t                  state;
  state_t                  state_nxt;
  logic [1:0]              gate;
  logic [K_W-1:0]          k;
  logic                    issue;
  logic                    acc_clr;
  logic signed [ACC_W-1:0] acc;
  logic signed [31:0]      biased;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    busy       = (state != S_IDLE);
    done       = 1'b0;
    wmem_rd_en = 1'b0;
    gate_valid = 1'b0;
    issue      = 1'b0;
    acc_clr    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_ISSUE;
          acc_clr   = 1'b1;
        end
      end
      S_ISSUE: begin
        wmem_rd_en = 1'b1;
        issue      = 1'b1;
        if (k == K_W'(ROW - 1)) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (k == K_W'(1)) state_nxt = S_BIAS;
      end
      S_BIAS: state_nxt = S_OUT;
      S_OUT: begin
        gate_valid = 1'b1;
        if (gate_ready) begin
          if (gate == GATE_O) begin
            state_nxt = S_FIN;
          end else begin
            state_nxt = S_ISSUE;
            acc_clr   = 1'b1;
          end
        end
      end
      S_FIN: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    // Abort overrides everything, including a simultaneous start in IDLE.
    if (abort) state_nxt = S_IDLE;
  end

  assign biased = 32'($signed(acc)) + 32'($signed(bias_data));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gate        <= '0;
      k           <= '0;
      gate_id     <= '0;
      gate_preact <= '0;
    end else if (abort) begin
      gate <= '0;
      k    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          gate <= '0;
          k    <= '0;
        end
        S_ISSUE: k <= (k == K_W'(ROW - 1)) ? '0 : k + K_W'(1);
        S_DRAIN: k <= (k == K_W'(1)) ? '0 : k + K_W'(1);
        S_BIAS: begin
          gate_preact <= sat16(biased);
          gate_id     <= gate;
        end
        S_OUT: begin
          if (gate_ready && gate != GATE_O) gate <= gate + 2'd1;
        end
        S_FIN: gate <= '0;
        default: k <= '0;
      endcase
    end
  end

  // Element k < N_X reads the x_t bank, the rest read h_prev.
  always_comb begin
    wmem_addr = '0;
    act_sel   = 1'b0;
    act_idx   = '0;
    if (state == S_ISSUE) begin
      wmem_addr = ADDR_W'(int'(gate) * ROW + int'(k));
      if (int'(k) < N_X) begin
        act_idx = IDX_W'(k);
      end else begin
        act_sel = 1'b1;
        act_idx = IDX_W'(int'(k) - N_X);
      end
    end
  end

  assign bias_idx = gate;

  lstm_operand_pipe #(
    .ACC_W(ACC_W)
  ) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .flush     (abort),
    .issue     (issue),
    .acc_clr   (acc_clr),
    .act_in    (act_data),
    .wmem_data (wmem_data),
    .mac_psum  (mac_psum),
    .mac_weight(mac_weight),
    .mac_act   (mac_act),
    .acc       (acc)
  );

endmodule
